pwm_capture: RTL and testbench

- Receive-side counterpart of pwm_generator: measures an incoming PWM waveform and reports period, frequency and duty in the same encodings pwm_generator consumes: duty 16-bit fraction of full scale, freq 32-bit Hz.
- Sits on an external or looped-back PWM line; used for closed-loop checks and for decoding PWM-coded sensor inputs.
- One shared sequential divider produces duty and freq; the block is fully synchronous after the input synchronizer.

---
 rtl/pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_pwm_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and frequency of an asynchronous PWM line.
// Results use pwm_generator's encodings: duty is a 16-bit fraction of full scale and
// freq is in Hz. One shared restoring divider computes duty, then freq.
module pwm_capture #(
    parameter int unsigned CLOCK_FREQ     = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [31:0] period,
    output logic [31:0] freq,
    output logic [15:0] duty,
    output logic        valid,
    output logic        stuck,
    output logic        overrun
);

    localparam logic [31:0] TimeoutVal = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] ClockVal   = 32'(CLOCK_FREQ);

    typedef enum logic [1:0] {StIdle, StDivDuty, StDivFreq, StDone} state_e;

    // Front end: synchronizer, edge detect, period counter, arming
    logic        pwm_s1, pwm_s2, pwm_prev;
    logic        rise, fall;
    logic [31:0] cnt;
    logic [31:0] hi_cap;
    logic        armed, seen_fall;
    logic        complete, timeout;

    // Divider / FSM state
    state_e      state;
    logic [31:0] per_sh;
    logic [31:0] rem;
    logic [31:0] dq;        // dividend bits shift out the top, quotient bits shift in
    logic [4:0]  iter;
    logic [15:0] duty_res;

    logic [32:0] trial, diff;
    logic        ge;
    logic [31:0] rem_nxt, dq_nxt;

    assign rise     = pwm_s2 & ~pwm_prev;
    assign fall     = ~pwm_s2 & pwm_prev;
    assign complete = rise & armed & seen_fall;
    // A rise in the same cycle reloads the counter, so it takes priority
    assign timeout  = (cnt == TimeoutVal) & ~stuck & ~rise;

    // One restoring-division step on the shared rem/dq registers
    always_comb begin
        trial   = {rem, dq[31]};
        diff    = trial - {1'b0, per_sh};
        ge      = (trial >= {1'b0, per_sh});
        rem_nxt = ge ? diff[31:0] : trial[31:0];
        dq_nxt  = {dq[30:0], ge};
    end

    // Input synchronizer, period counter and measurement arming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_s1    <= 1'b0;
            pwm_s2    <= 1'b0;
            pwm_prev  <= 1'b0;
            cnt       <= 32'd0;
            hi_cap    <= 32'd0;
            armed     <= 1'b0;
            seen_fall <= 1'b0;
        end else begin
            pwm_s1   <= pwm_in;
            pwm_s2   <= pwm_s1;
            pwm_prev <= pwm_s2;

            if (rise) begin
                cnt <= 32'd1;
            end else if (cnt < TimeoutVal) begin
                cnt <= cnt + 32'd1;
            end

            if (rise) begin
                armed     <= 1'b1;
                seen_fall <= 1'b0;
            end else if (timeout) begin
                armed     <= 1'b0;
                seen_fall <= 1'b0;
            end else if (fall && armed) begin
                hi_cap    <= cnt;
                seen_fall <= 1'b1;
            end
        end
    end

    // Divide sequencer with registered, atomically updated result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            per_sh   <= 32'd0;
            rem      <= 32'd0;
            dq       <= 32'd0;
            iter     <= 5'd0;
            duty_res <= 16'd0;
            period   <= 32'd0;
            freq     <= 32'd0;
            duty     <= 16'd0;
            valid    <= 1'b0;
            stuck    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            if (timeout) begin
                // Abort any divide in progress; report the static level
                state  <= StIdle;
                stuck  <= 1'b1;
                period <= 32'd0;
                freq   <= 32'd0;
                duty   <= pwm_s2 ? 16'hFFFF : 16'h0000;
                valid  <= 1'b1;
            end else begin
                if (complete && state != StIdle) begin
                    overrun <= 1'b1;
                end
                case (state)
                    StIdle: begin
                        if (complete) begin
                            per_sh <= cnt;
                            // {hi,16'b0}/per: top 16 bits of hi are already < per,
                            // so they preload the remainder and 32 steps suffice
                            rem    <= {16'd0, hi_cap[31:16]};
                            dq     <= {hi_cap[15:0], 16'd0};
                            iter   <= 5'd0;
                            state  <= StDivDuty;
                        end
                    end
                    StDivDuty: begin
                        rem  <= rem_nxt;
                        dq   <= dq_nxt;
                        iter <= iter + 5'd1;
                        if (iter == 5'd31) begin
                            duty_res <= dq_nxt[15:0];
                            rem      <= 32'd0;
                            dq       <= ClockVal;
                            iter     <= 5'd0;
                            state    <= StDivFreq;
                        end
                    end
                    StDivFreq: begin
                        rem  <= rem_nxt;
                        dq   <= dq_nxt;
                        iter <= iter + 5'd1;
                        if (iter == 5'd31) begin
                            state <= StDone;
                        end
                    end
                    StDone: begin
                        period <= per_sh;
                        duty   <= duty_res;
                        freq   <= dq;
                        stuck  <= 1'b0;
                        valid  <= 1'b1;
                        state  <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: direct-drives PWM waveforms, predicts every published result
// (values and arrival cycle) into a scoreboard queue and compares on each valid pulse.
module tb_pwm_capture;

    localparam int unsigned CF = 100_000_000;
    localparam int unsigned TO = 20_000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [31:0] period;
    logic [31:0] freq;
    logic [15:0] duty;
    logic        valid;
    logic        stuck;
    logic        overrun;

    always #5 clk = ~clk;

    pwm_capture #(
        .CLOCK_FREQ    (CF),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .period (period),
        .freq   (freq),
        .duty   (duty),
        .valid  (valid),
        .stuck  (stuck),
        .overrun(overrun)
    );

    typedef struct {
        logic [31:0] period;
        logic [31:0] freq;
        logic [15:0] duty;
        logic        stuck;
        longint      cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   got_e;
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Reference model state
    bit     model_armed = 1'b0;
    bit     have_prev   = 1'b0;
    int     prev_p, prev_h;
    longint last_acc    = -1_000_000_000;
    int     exp_ovr     = 0;
    int     seen_ovr    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: every valid pulse must match the oldest prediction
    always @(posedge clk) begin
        #1;
        if (!reset && overrun) seen_ovr++;
        if (!reset && valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                got_e = sb.pop_front();
                check("period", period, got_e.period);
                check("freq", freq, got_e.freq);
                check("duty", duty, got_e.duty);
                check("stuck", stuck, got_e.stuck);
                check("latency", cyc, got_e.cyc);
            end
        end
    end

    // Drive a rising edge; predict the result of the period it completes
    task automatic do_rise();
        exp_t   e;
        longint t;
        @(negedge clk);
        t = cyc;
        if (model_armed && have_prev) begin
            if (t - last_acc >= 66) begin
                e.period = 32'(prev_p);
                e.freq   = 32'(longint'(CF) / longint'(prev_p));
                e.duty   = 16'((longint'(prev_h) * 65536) / longint'(prev_p));
                e.stuck  = 1'b0;
                e.cyc    = t + 68;
                sb.push_back(e);
                last_acc = t;
            end else begin
                exp_ovr++;
            end
        end
        model_armed = 1'b1;
        pwm_in      = 1'b1;
    endtask

    task automatic pulse(input int p, input int h);
        do_rise();
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h - 1) @(negedge clk);
        prev_p    = p;
        prev_h    = h;
        have_prev = 1'b1;
    endtask

    task automatic go_low(input int n);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_period"}, period, 0);
        check({pfx, "_freq"}, freq, 0);
        check({pfx, "_duty"}, duty, 0);
        check({pfx, "_valid"}, valid, 0);
        check({pfx, "_stuck"}, stuck, 0);
        check({pfx, "_overrun"}, overrun, 0);
    endtask

    task automatic hold_high();
        exp_t   e;
        longint t0;
        do_rise();
        t0       = cyc;
        e.period = 32'd0;
        e.freq   = 32'd0;
        e.duty   = 16'hFFFF;
        e.stuck  = 1'b1;
        e.cyc    = t0 + 3 + TO;
        sb.push_back(e);
        model_armed = 1'b0;
        have_prev   = 1'b0;
        last_acc    = -1_000_000_000;
        repeat (TO + 20) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Measurement table; the first rise only arms
        pulse(1000, 500);
        pulse(2000, 500);
        pulse(10000, 1000);
        pulse(777, 100);
        pulse(300, 299);
        pulse(100, 1);

        // Static high line, then resume
        hold_high();
        check("stuck_level", stuck, 1);
        go_low(50);
        pulse(1000, 500);
        pulse(1000, 500);
        pulse(1000, 500);

        // Periods shorter than the divide latency
        for (int i = 0; i < 20; i++) pulse(40, 10);
        pulse(200, 50);

        // Reset in the middle of a duty divide
        do_rise();
        repeat (23) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        model_armed = 1'b0;
        have_prev   = 1'b0;
        last_acc    = -1_000_000_000;
        @(negedge clk);
        check_all_zero("midrst");
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        go_low(10);
        pulse(500, 125);
        pulse(500, 125);
        do_rise();
        repeat (100) @(negedge clk);
        go_low(10);

        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain", sb.size(), 0);
        check("overrun_count", seen_ovr, exp_ovr);
        check("overrun_seen", seen_ovr > 0, 1);
        check("final_stuck", stuck, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
